// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, timeout defaults and a funct3 legality helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_CYCLES_DEF = 16;
   localparam int CNT_W              = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction/extension and the misalign flag (only when LSU_MISALIGN_EN is defined).
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_illegal,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      if (i_we) begin
         case (i_funct3[1:0])
            2'b00: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
               o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
               o_be    = 4'b1111;
               o_wdata = i_wdata;
            end
         endcase
      end
   end

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Halfword lane depends on addr[1] only; addr[0] is a misalign concern.
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_rdata = {24'd0, w_byte};
         F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_rdata = {16'd0, w_half};
         default: o_rdata = i_rdata;
      endcase
   end

   assign o_illegal = ~f3_legal(i_we, i_funct3);

`ifdef LSU_MISALIGN_EN
   assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
`else
   assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store stage with req/gnt/rvalid memory port and
// access timeout. Optional misalign trapping via LSU_MISALIGN_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              resp_misalign,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        o_dbg_state
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t        r_state, w_next;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic              r_misalign;

   logic              w_accept, w_capture, w_timeout, w_cnt_hit;
   logic              w_sel_we;
   logic [2:0]        w_sel_f3;
   logic [1:0]        w_sel_lo;
   logic [31:0]       w_sel_wdata;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata_rep, w_load_data;
   logic              w_illegal, w_misalign;
   logic              w_in_req;

   // One align instance: decodes the incoming request in IDLE, the latched one afterwards.
   assign w_sel_we    = (r_state == IDLE) ? req_we     : r_we;
   assign w_sel_f3    = (r_state == IDLE) ? req_funct3 : r_funct3;
   assign w_sel_lo    = (r_state == IDLE) ? req_addr[1:0] : r_addr[1:0];
   assign w_sel_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;

   lsu_align u_align (
      .i_we       (w_sel_we),
      .i_funct3   (w_sel_f3),
      .i_addr_lo  (w_sel_lo),
      .i_wdata    (w_sel_wdata),
      .i_rdata    (mem_rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata_rep),
      .o_rdata    (w_load_data),
      .o_illegal  (w_illegal),
      .o_misalign (w_misalign)
   );

   // >= so a load granted on the last REQ cycle still times out in WAIT.
   assign w_cnt_hit = (r_cnt >= LP_CNT_LAST);

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               w_next   = (w_illegal || w_misalign) ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               w_next = r_we ? RESP : WAIT;
            end else if (w_cnt_hit) begin
               w_next    = RESP;
               w_timeout = 1'b1;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               w_next    = RESP;
               w_capture = 1'b1;
            end else if (w_cnt_hit) begin
               w_next    = RESP;
               w_timeout = 1'b1;
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_cnt      <= '0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= '0;
            r_rdata    <= 32'd0;
            r_err      <= w_illegal | w_misalign;
            r_misalign <= w_misalign & ~w_illegal;
         end
         if ((r_state == REQ) || (r_state == WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
         if (w_capture) begin
            r_rdata <= w_load_data;
         end
      end
   end

   assign w_in_req = (r_state == REQ);

   assign req_ready     = (r_state == IDLE);
   assign resp_valid    = (r_state == RESP);
   assign resp_rdata    = resp_valid ? r_rdata : 32'd0;
   assign resp_err      = resp_valid & r_err;
   assign resp_misalign = resp_valid & r_misalign;
   // Gated by rst so the pipeline is released immediately while reset is held.
   assign stall         = req_valid & ~resp_valid & rst;

   assign mem_req   = w_in_req;
   assign mem_we    = w_in_req & r_we;
   assign mem_addr  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem_be    = w_in_req ? w_be : 4'b0000;
   assign mem_wdata = w_in_req ? w_wdata_rep : 32'd0;

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a
// req/gnt/rvalid memory responder, response scoreboard, plus reset corner cases.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // {err, misalign, rdata}
  logic [33:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gw;
    logic        rv_en;
    int          exp_lat;
    int          exp_reqs;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_misalign (resp_misalign),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int gw,
                              input logic rv_en, input int lat, input int reqs,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input logic eerr, input logic emis);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gw = gw; v.rv_en = rv_en; v.exp_lat = lat; v.exp_reqs = reqs;
    v.exp_addr = eaddr; v.exp_be = ebe; v.exp_wd = ewd; v.exp_rd = erd;
    v.exp_err = eerr; v.exp_mis = emis;
    return v;
  endfunction

  // driver + memory responder for one access
  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    int          reqs;
    logic        done;
    logic        gnt_prev;
    logic        gnt_now;
    logic [33:0] exp;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_mis, v.exp_rd});
    #1;
    chk($sformatf("v%0d_ready_idle", idx), req_ready, 1'b1);
    chk($sformatf("v%0d_stall_accept", idx), stall, 1'b1);
    cyc = 0; reqs = 0; done = 1'b0; gnt_prev = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      gnt_now    = 1'b0;
      if (resp_valid) begin
        done      = 1'b1;
        exp       = exp_q.pop_front();
        chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        chk($sformatf("v%0d_err", idx), resp_err, exp[33]);
        chk($sformatf("v%0d_misalign", idx), resp_misalign, exp[32]);
        chk($sformatf("v%0d_rdata", idx), resp_rdata, exp[31:0]);
        chk($sformatf("v%0d_stall_resp", idx), stall, 1'b0);
        chk($sformatf("v%0d_ready_resp", idx), req_ready, 1'b0);
        chk($sformatf("v%0d_mem_req_cycles", idx), reqs, v.exp_reqs);
        req_valid = 1'b0;
      end else begin
        if (mem_req) begin
          reqs++;
          chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
          chk($sformatf("v%0d_mem_be", idx), mem_be, v.exp_be);
          chk($sformatf("v%0d_mem_we", idx), mem_we, v.we);
          if (v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wd);
          if (cyc > v.gw) begin
            mem_gnt = 1'b1;
            gnt_now = 1'b1;
          end
        end
        if (gnt_prev && !v.we && v.rv_en) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
        gnt_prev = gnt_now;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL v%0d_resp_wait: no resp_valid within 40 cycles, expected latency %0d", idx, v.exp_lat);
      void'(exp_q.pop_front());
      req_valid = 1'b0;
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk($sformatf("v%0d_no_second_access", idx), mem_req, 1'b0);
  endtask

  // reset asserted mid-transaction (in REQ or WAIT), then late gnt/rvalid
  task automatic reset_mid(input logic in_wait);
    string tag;
    logic  seen;
    tag = in_wait ? "rst_wait" : "rst_req";
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0600;
    req_wdata  = 32'd0;
    @(negedge clk);
    mem_gnt = in_wait;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk({tag, "_pre_mem_req"}, mem_req, !in_wait);
    chk({tag, "_pre_stall"}, stall, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_state"}, dbg_state, 2'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (resp_valid || mem_req) seen = 1'b1;
    end
    chk({tag, "_late_rvalid_ignored"}, seen, 1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;

    // we f3 addr wdata rdata gw rv lat reqs eaddr ebe ewd erd err mis
    vecs.push_back(mk(1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 1, 2, 1, 32'h104, 4'b1111, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 1, 2, 1, 32'h200, 4'b1000, 32'hA5A5A5A5, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234CAFE, 0, 0, 1, 2, 1, 32'h100, 4'b1100, 32'hCAFECAFE, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h201, 32'h00000011, 0, 0, 1, 2, 1, 32'h200, 4'b0010, 32'h11111111, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h200, 32'h0000BEEF, 0, 2, 1, 4, 3, 32'h200, 4'b0011, 32'hBEEFBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h301, 0, 32'h00008000, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h301, 0, 32'h00008000, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'h00000080, 0, 0));
    vecs.push_back(mk(0, 3'b101, 32'h302, 0, 32'hBEEF0000, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'h0000BEEF, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h302, 0, 32'hBEEF0000, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'hFFFFBEEF, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h300, 0, 32'h00007FFF, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'h00007FFF, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h303, 0, 32'h81000000, 0, 1, 3, 1, 32'h300, 4'b1111, 0, 32'hFFFFFF81, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h400, 0, 32'h12345678, 1, 1, 4, 2, 32'h400, 4'b1111, 0, 32'h12345678, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b110, 32'h000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b100, 32'h000, 32'h55, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
`ifdef LSU_MISALIGN_EN
    vecs.push_back(mk(0, 3'b010, 32'h102, 0, 32'hA1B2C3D4, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b001, 32'h101, 32'h0000ABCD, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
`else
    vecs.push_back(mk(0, 3'b010, 32'h102, 0, 32'hA1B2C3D4, 0, 1, 3, 1, 32'h100, 4'b1111, 0, 32'hA1B2C3D4, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h101, 32'h0000ABCD, 0, 0, 1, 2, 1, 32'h100, 4'b0011, 32'hABCDABCD, 0, 0, 0));
`endif
    // timeout with no gnt, timeout in WAIT, and gnt arriving on the timeout cycle
    vecs.push_back(mk(0, 3'b010, 32'h500, 0, 32'hFFFFFFFF, 99, 1, 17, 16, 32'h500, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b010, 32'h504, 0, 32'hFFFFFFFF, 0, 0, 17, 1, 32'h504, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b010, 32'h700, 32'h0BADF00D, 0, 15, 1, 17, 16, 32'h700, 4'b1111, 32'h0BADF00D, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h704, 0, 32'h55AA55AA, 15, 1, 18, 16, 32'h704, 4'b1111, 0, 32'h55AA55AA, 0, 0));

    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_mem_be", mem_be, 4'b0000);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_state", dbg_state, 2'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    reset_mid(1'b1);
    reset_mid(1'b0);

    // the unit must still work normally after a mid-transaction reset
    run_vec(99, vecs[0]);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access stage between the ALU (address and store data) and the result-select mux (load data) of the RISC-V core. It accepts one load or store per instruction, drives a req/gnt/rvalid data-memory port with byte enables, and aligns and sign- or zero-extends load data. It stalls PC update until the access completes and flags illegal, misaligned or timed-out accesses.

Parameters:
ADDR_W, 32, byte-address width of the request and memory port.
TIMEOUT_CYCLES, 16, maximum cycles spent in REQ plus WAIT before an error response; range 2..255.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  core presents a load/store; held high until the resp_valid cycle.
req_ready  out  1  high only in IDLE.
req_we  in  1  1=store, 0=load.
req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
req_addr  in  ADDR_W  byte address (ALU result).
req_wdata  in  32  store data (rs2).
stall  out  1  req_valid & ~resp_valid; blocks PC and regfile write.
resp_valid  out  1  one-cycle pulse; access complete.
resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
resp_err  out  1  qualified by resp_valid: illegal funct3, misalign or timeout.
resp_misalign  out  1  qualified by resp_valid; misalign cause.
mem_req  out  1  memory request.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  word address, low 2 bits forced to 0.
mem_be  out  4  byte enables.
mem_wdata  out  32  lane-replicated store data.
mem_gnt  in  1  request accepted this cycle.
mem_rvalid  in  1  read data valid.
mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst=0): state IDLE, timeout counter 0; all outputs 0 except req_ready=1. mem_req drops immediately on reset mid-transaction; in-flight mem_rvalid is ignored.
- Accept on req_valid & req_ready: latch we, funct3, addr, wdata. Inputs are not used after the accept.
- States: IDLE -> REQ (legal access) or IDLE -> RESP with err (illegal funct3: loads 011/110/111, stores 011-111). No memory access on error.
- REQ: mem_req=1; address, be and wdata are stable until gnt. On gnt, a store goes to RESP; a load goes to WAIT.
- WAIT: on mem_rvalid, capture the extracted value and go to RESP. rvalid arrives no earlier than the cycle after gnt; rvalid seen in REQ is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RESP, so the still-high req_valid of the finishing instruction is not re-accepted.
- Timeout: counter clears on accept and increments each cycle in REQ/WAIT. At TIMEOUT_CYCLES the unit goes to RESP with resp_err=1 and rdata=0. A gnt or rvalid arriving in the same cycle as the timeout wins; no error in that case.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: addr[1] ? 4'b1100 : 4'b0011
  - SW: 4'b1111
  - Loads: 4'b1111
- Store data lanes: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction: byte selected by addr[1:0], half by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Best-case latency accept->resp_valid: store 2 cycles (gnt in first REQ cycle); load 3 cycles (rvalid the cycle after gnt).

Optional Feature:
Macro LSU_MISALIGN_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE->RESP with resp_err=1, resp_misalign=1 and no memory access.
- Undefined: misaligned low bits are ignored (halfword uses addr[1] only, word uses addr[31:2]); resp_misalign is tied 0.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding (IDLE, REQ, WAIT, RESP), default TIMEOUT_CYCLES.
- Sub-module lsu_align: combinational; computes be, wdata replication, load extraction and the misalign flag. Instantiated once.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, gnt in 1st REQ cycle -> mem_addr 0x104, be 1111, mem_wdata 0xDEADBEEF, resp_valid 2 cycles after accept, err 0.
- SB addr 0x203, wdata 0x000000A5 -> be 1000, mem_wdata 0xA5A5A5A5.
- LB addr 0x301, mem_rdata 0x0000_80_00 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x302, rdata 0xBEEF0000 -> 0x0000BEEF.
- Load with gnt never asserted, TIMEOUT_CYCLES=16 -> resp_valid, err=1, rdata 0 exactly 16 cycles after entering REQ; no second access follows.
- LW addr 0x102: with LSU_MISALIGN_EN -> err=1, misalign=1, mem_req never high; without it -> mem_addr 0x100, normal completion.
- rst low while in WAIT -> mem_req, resp_valid, stall 0 immediately; a late rvalid after reset release produces no resp_valid.
